// File: rtl/ones_count_pkg.sv
`default_nettype none
// ============================================================
// Package : ones_count_pkg
// Shared widths, FSM state type and sum-width helper.
// Rev     : 1.0
// ============================================================
package ones_count_pkg;

  localparam int CNT_W   = 4;
  localparam int MAX_CNT = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } win_state_t;

  // Width that holds the largest possible window sum without overflow.
  function automatic int acc_width(input int window);
    return $clog2(MAX_CNT * window + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ones_count_minmax.sv
`default_nettype none
// ============================================================
// Module : ones_count_minmax
// Running max/min of 4-bit samples with load and update enables.
// Rev    : 1.0
// ============================================================
module ones_count_minmax
  import ones_count_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             update,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] mx,
  output logic [CNT_W-1:0] mn,
  output logic [CNT_W-1:0] nxt_mx,
  output logic [CNT_W-1:0] nxt_mn
);

  // Next values are exposed so the closing sample can be folded in same-cycle.
  always_comb begin
    nxt_mx = mx;
    nxt_mn = mn;
    if (load) begin
      nxt_mx = din;
      nxt_mn = din;
    end else begin
      nxt_mx = (din > mx) ? din : mx;
      nxt_mn = (din < mn) ? din : mn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx <= '0;
      mn <= '0;
    end else if (clr) begin
      mx <= '0;
      mn <= '0;
    end else if (load || update) begin
      mx <= nxt_mx;
      mn <= nxt_mn;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ones_count_window.sv
`default_nettype none
// ============================================================
// Module : ones_count_window
// Windowed sum/max/min of ones-counter samples; one strobe per window.
// Rev    : 1.0
// ============================================================
module ones_count_window
  import ones_count_pkg::*;
#(
  parameter  int WINDOW = 8,
  localparam int ACC_W  = acc_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             in_valid,
  input  logic             clear,
  input  logic [ACC_W-1:0] thresh,
  output logic [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0] max_out,
  output logic [CNT_W-1:0] min_out,
  output logic             above,
  output logic             out_valid,
  output logic             busy
);

  localparam int IDX_W = $clog2(WINDOW);

  win_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic             w_take;
  logic             w_load;
  logic             w_update;
  logic             w_close;
  logic [CNT_W-1:0] w_mx;
  logic [CNT_W-1:0] w_mn;
  logic [CNT_W-1:0] w_nxt_mx;
  logic [CNT_W-1:0] w_nxt_mn;

  assign w_take   = in_valid && !clear;
  assign w_load   = w_take && (r_state == IDLE);
  assign w_update = w_take && (r_state == ACCUM);
  assign w_close  = w_update && (r_idx == IDX_W'(WINDOW - 1));
  assign w_sum    = r_acc + ACC_W'(cnt_in);
  assign busy     = (r_state == ACCUM);

  ones_count_minmax u_minmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clear),
    .load   (w_load),
    .update (w_update),
    .din    (cnt_in),
    .mx     (w_mx),
    .mn     (w_mn),
    .nxt_mx (w_nxt_mx),
    .nxt_mn (w_nxt_mn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_acc     <= '0;
      sum_out   <= '0;
      max_out   <= '0;
      min_out   <= '0;
      above     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_acc   <= '0;
      end else if (w_load) begin
        r_state <= ACCUM;
        r_idx   <= IDX_W'(1);
        r_acc   <= ACC_W'(cnt_in);
      end else if (w_close) begin
        // Closing sample is folded into the published result directly.
        r_state   <= IDLE;
        r_idx     <= '0;
        r_acc     <= '0;
        sum_out   <= w_sum;
        max_out   <= w_nxt_mx;
        min_out   <= w_nxt_mn;
        above     <= (w_sum > thresh);
        out_valid <= 1'b1;
      end else if (w_update) begin
        r_idx <= r_idx + IDX_W'(1);
        r_acc <= w_sum;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ones_count_window.md
# ones_count_window

Downstream stage for the fifteen-input ones counter. It takes the counter's 4-bit result (0..15) as a valid-qualified sample each clock. Over a window of WINDOW accepted samples it accumulates the sum, the maximum and the minimum. At the end of each window it publishes one registered result with a one-cycle strobe and a threshold flag.

## Interface
- WINDOW, 8: samples per window; legal range 2..256.
- ACC_W (localparam), $clog2(15*WINDOW+1): sum width; 7 for WINDOW=8.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cnt_in  input  4  ones count from the upstream counter, bit 3 = y3 … bit 0 = y0.
- in_valid  input  1  cnt_in is a sample this cycle.
- clear  input  1  synchronous abort of the current window.
- thresh  input  ACC_W  compare level for the `above` flag; sampled only on the window-closing edge.
- sum_out  output  ACC_W  sum of the last completed window.
- max_out  output  4  largest sample of the last completed window.
- min_out  output  4  smallest sample of the last completed window.
- above  output  1  sum_out > thresh for the last completed window.
- out_valid  output  1  one-cycle strobe: new result on the outputs.
- busy  output  1  a window is partially filled (state ACCUM).

## Operation
- **FSM states:**
  - IDLE: no samples held.
  - ACCUM: 1..WINDOW-1 samples held.
- **IDLE + in_valid:** acc=cnt_in, mx=mn=cnt_in, idx=1, go to ACCUM.
- **ACCUM + in_valid, idx<WINDOW-1:** acc+=cnt_in, mx=max(mx,cnt_in), mn=min(mn,cnt_in), idx++.
- **ACCUM + in_valid, idx==WINDOW-1 (window close):**
  - sum_out=acc+cnt_in.
  - max_out and min_out include cnt_in.
  - above=(acc+cnt_in)>thresh.
  - out_valid=1 for exactly one cycle.
  - Return to IDLE.
- **No in_valid:** state, internal accumulators and outputs hold.
- **clear:**
  - Priority over in_valid.
  - Go to IDLE, idx=0, acc=0.
  - The sample presented with clear is discarded.
  - sum_out/max_out/min_out/above keep the last completed result.
  - No strobe.
- **Widths:** the sum cannot overflow (15*WINDOW fits in ACC_W). Comparisons are unsigned.
- **Samples of value 0 and 15** are legal and update min/max normally.

## Timing
- **Reset (rst_n=0, asynchronous):**
  - State IDLE; idx, acc, mx, mn cleared to 0.
  - sum_out=0, max_out=0, min_out=0, above=0, out_valid=0, busy=0.
- **Reset mid-window:** the partial window is lost and no strobe is produced.
- **Latency:** out_valid and the new outputs appear on the rising edge that accepts the WINDOW-th sample, i.e. visible in the following cycle.
- **Back-to-back windows:**
  - A valid sample in the cycle where out_valid=1 is accepted as sample 1 of the next window.
  - Throughput is one sample per cycle with no dead cycle.
- **busy:** 1 while in ACCUM; 0 in IDLE, including the out_valid cycle.
- **clear and the closing sample together:** clear wins; no result, outputs unchanged.
- **Input timing:** cnt_in must be stable at the sampling edge. The upstream counter's settle time must fit within one clk period.

## Structure
- **Package ones_count_pkg:**
  - CNT_W=4, MAX_CNT=15.
  - typedef enum logic {IDLE, ACCUM} win_state_t.
  - Function acc_width(window) returning $clog2(15*window+1).
- **Sub-module ones_count_minmax:** running 4-bit max/min registers with load (first sample) and update enables; used once.
- **Top level:** FSM, idx counter, accumulator, output registers.

## Test plan
- **Reset and first window:** WINDOW=4, thresh=20. Assert rst_n=0 mid-idle, release; then samples 15,0,7,3 on consecutive cycles → sum_out=25, max_out=15, min_out=0, above=1, out_valid high one cycle after the 4th sample, busy 1 for cycles 2–4.
- **Gaps in valid:** samples 1,1,1,1 with in_valid low for 3 cycles between each → sum_out=4, max=min=1, above=0; outputs unchanged during gaps.
- **Back-to-back windows:** 8 consecutive samples, all 15 → two strobes exactly 4 cycles apart, each sum_out=60, max=min=15; no dead cycle.
- **clear:**
  - 3 samples of 5, then clear together with a 4th valid sample → no strobe, prior outputs held, busy=0.
  - Then 4,4,4,4 → sum_out=16.
- **Mid-window reset:** 2 samples, then rst_n=0 for 1 cycle → all outputs 0. The next full window of 2,2,2,2 → sum_out=8 and a single strobe.
- **Maximum sum:** WINDOW=256, all samples 15, thresh=3839 → sum_out=3840 (ACC_W=12, no overflow), above=1.
